// File: rtl/circulant_transpose_ctrl.sv
// circulant_transpose_ctrl
//   Sequencer for a circulant column-chunked transpose memory. It fills one
//   MATRIX_DIM x MATRIX_DIM matrix of COL_WIDTH-bit chunks row-major from a
//   valid/ready word stream. It then drains the matrix column-major through the
//   memory read port into a valid/ready output stream. This block is the only
//   master of both memory ports.
//
//   Ports
//     clk, rst_n                 clock, asynchronous active-low reset
//     in_valid/in_ready/in_data  input word stream (accepted in IDLE and FILL)
//     out_valid/out_ready/out_data/out_last
//                                output word stream; out_last marks the final word
//     write_en/write_row/write_col/mem_wdata
//                                memory write port (base column = word * CPW)
//     read_en/read_row/read_col/mem_rdata
//                                memory read port; mem_rdata is valid one cycle
//                                after read_en
//     busy                       controller is not idle
//
//   Optional feature macro: CIRC_XPOSE_STATS_EN adds matrix_count[15:0]
//   (wrapping count of completed matrices) and stall_count[15:0] (saturating
//   count of cycles with out_valid & !out_ready).
module circulant_transpose_ctrl #(
  parameter int MATRIX_DIM = 4,
  parameter int COL_WIDTH  = 8,
  parameter int WORD_LEN   = 32,
  parameter int ADDR_LEN   = $clog2(MATRIX_DIM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_LEN-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] out_data,
  output logic                out_last,
  output logic                write_en,
  output logic [ADDR_LEN-1:0] write_row,
  output logic [ADDR_LEN-1:0] write_col,
  output logic [WORD_LEN-1:0] mem_wdata,
  output logic                read_en,
  output logic [ADDR_LEN-1:0] read_row,
  output logic [ADDR_LEN-1:0] read_col,
  input  logic [WORD_LEN-1:0] mem_rdata,
`ifdef CIRC_XPOSE_STATS_EN
  output logic [15:0]         matrix_count,
  output logic [15:0]         stall_count,
`endif
  output logic                busy
);

  localparam int CPW    = WORD_LEN / COL_WIDTH;
  localparam int WPR    = MATRIX_DIM / CPW;
  localparam int NWORDS = MATRIX_DIM * WPR;
  localparam int WW     = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RW     = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [WW-1:0]       wr_w, rd_w;
  logic [ADDR_LEN-1:0] wr_row, rd_row;
  logic [RW-1:0]       reads_issued;
  logic                rd_pending, rd_pending_last;
  logic [WORD_LEN-1:0] fifo_data [2];
  logic [1:0]          fifo_last;
  logic                fifo_wp, fifo_rp;
  logic [1:0]          fifo_count;
  logic [2:0]          occ_after_pop;
  logic                push, pop, last_wr, last_rd, drain_done;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Write side: purely combinational from the input handshake
  assign in_ready  = (state != DRAIN);
  assign write_en  = in_valid & in_ready;
  assign mem_wdata = in_data;
  assign write_row = wr_row;
  assign write_col = ADDR_LEN'(wr_w * CPW);
  assign last_wr   = write_en && (wr_row == ADDR_LEN'(MATRIX_DIM - 1)) && (wr_w == WW'(WPR - 1));

  // Read side: column-major walk, rows inner
  assign read_row = rd_row;
  assign read_col = ADDR_LEN'(rd_w * CPW);
  assign last_rd  = (reads_issued == RW'(NWORDS - 1));

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = rd_pending;
  assign out_data  = out_valid ? fifo_data[fifo_rp] : '0;
  assign out_last  = out_valid & fifo_last[fifo_rp];
  assign drain_done = pop & fifo_last[fifo_rp];

  // Credit: FIFO occupancy after this cycle's pop plus the read still in
  // flight must leave room for one more word. Counting the pop keeps the
  // stream at one word per cycle while out_ready stays high.
  assign occ_after_pop = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop};
  assign read_en = (state == DRAIN) && (reads_issued < RW'(NWORDS)) && (occ_after_pop < 3'd2);

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (write_en) state_nxt = last_wr ? DRAIN : FILL;
      FILL:    if (last_wr) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stage p0: address counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_w         <= '0;
      wr_row       <= '0;
      rd_w         <= '0;
      rd_row       <= '0;
      reads_issued <= '0;
    end else begin
      if (write_en) begin
        if (wr_w == WW'(WPR - 1)) begin
          wr_w   <= '0;
          wr_row <= (wr_row == ADDR_LEN'(MATRIX_DIM - 1)) ? '0 : wr_row + 1'b1;
        end else begin
          wr_w <= wr_w + 1'b1;
        end
      end
      if (read_en) begin
        if (rd_row == ADDR_LEN'(MATRIX_DIM - 1)) begin
          rd_row <= '0;
          rd_w   <= (rd_w == WW'(WPR - 1)) ? '0 : rd_w + 1'b1;
        end else begin
          rd_row <= rd_row + 1'b1;
        end
      end
      if (drain_done)   reads_issued <= '0;
      else if (read_en) reads_issued <= reads_issued + 1'b1;
    end
  end

  // Stage p1: read in flight; mem_rdata lands in the output FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
      fifo_wp         <= 1'b0;
      fifo_rp         <= 1'b0;
      fifo_count      <= 2'd0;
      fifo_last       <= 2'b00;
    end else begin
      rd_pending      <= read_en;
      rd_pending_last <= read_en & last_rd;
      if (push) begin
        fifo_last[fifo_wp] <= rd_pending_last;
        fifo_wp            <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_data[fifo_wp] <= mem_rdata;
  end

`ifdef CIRC_XPOSE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matrix_count <= 16'd0;
      stall_count  <= 16'd0;
    end else begin
      if (drain_done) matrix_count <= matrix_count + 16'd1;
      if (out_valid && !out_ready) stall_count <= sat_inc16(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_circulant_transpose_ctrl.sv
// Testbench for circulant_transpose_ctrl with MATRIX_DIM=4, COL_WIDTH=8,
// WORD_LEN=16 (two chunks per word, two words per row, eight words per matrix).
// A chunk-array memory model serves the DUT's memory ports. A behavioural model
// tracks words accepted, reads issued and words delivered, and checks every
// cycle on the falling edge.
module tb_circulant_transpose_ctrl;

  localparam int DIM = 4;
  localparam int CW  = 8;
  localparam int WL  = 16;
  localparam int AL  = 2;
  localparam int CPW = WL / CW;
  localparam int WPR = DIM / CPW;
  localparam int NW  = DIM * WPR;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WL-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WL-1:0] out_data;
  logic          out_last;
  logic          write_en;
  logic [AL-1:0] write_row, write_col;
  logic [WL-1:0] mem_wdata;
  logic          read_en;
  logic [AL-1:0] read_row, read_col;
  logic [WL-1:0] mem_rdata = '0;
  logic          busy;
`ifdef CIRC_XPOSE_STATS_EN
  logic [15:0]   matrix_count, stall_count;
  logic [15:0]   mat_m, stall_m;
`endif

  circulant_transpose_ctrl #(
    .MATRIX_DIM(DIM), .COL_WIDTH(CW), .WORD_LEN(WL), .ADDR_LEN(AL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .write_en(write_en), .write_row(write_row), .write_col(write_col), .mem_wdata(mem_wdata),
    .read_en(read_en), .read_row(read_row), .read_col(read_col), .mem_rdata(mem_rdata),
`ifdef CIRC_XPOSE_STATS_EN
    .matrix_count(matrix_count), .stall_count(stall_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Chunk-addressed memory: a word at (row, col) spans chunks col..col+CPW-1
  logic [CW-1:0] chunk [DIM][DIM];
  always @(posedge clk) begin
    if (write_en)
      for (int k = 0; k < CPW; k++) chunk[write_row][int'(write_col) + k] <= mem_wdata[k*CW +: CW];
    if (read_en)
      for (int k = 0; k < CPW; k++) mem_rdata[k*CW +: CW] <= chunk[read_row][int'(read_col) + k];
  end

  // Behavioural model
  int            acc_cnt = 0;
  int            rd_cnt  = 0;
  int            out_cnt = 0;
  int            mat_done = 0;
  int            gidx;
  bit            exp_ir;
  logic [WL-1:0] golden [NW];
  logic [WL-1:0] out_log [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_read_en", read_en, 0);
      chk("rst_write_en", write_en, 0);
      chk("rst_busy", busy, 0);
      acc_cnt = 0; rd_cnt = 0; out_cnt = 0;
`ifdef CIRC_XPOSE_STATS_EN
      mat_m = 0; stall_m = 0;
      chk("rst_matrix_count", matrix_count, 0);
      chk("rst_stall_count", stall_count, 0);
`endif
    end else begin
      exp_ir = (acc_cnt != NW);
      chk("in_ready", in_ready, exp_ir);
      chk("busy", busy, acc_cnt != 0);
      chk("write_en", write_en, in_valid & exp_ir);
      if (write_en) begin
        chk("write_row", write_row, acc_cnt / WPR);
        chk("write_col", write_col, (acc_cnt % WPR) * CPW);
        chk("mem_wdata", mem_wdata, in_data);
      end
      if (exp_ir) begin
        chk("out_valid_idle", out_valid, 0);
        chk("read_en_idle", read_en, 0);
      end
      if (read_en) begin
        chk("read_budget", rd_cnt < NW, 1);
        chk("read_row", read_row, rd_cnt % DIM);
        chk("read_col", read_col, (rd_cnt / DIM) * CPW);
      end
      chk("credit", (rd_cnt - out_cnt) <= 2, 1);
      chk("out_last", out_last, out_valid && (out_cnt == NW - 1));
      if (out_valid) begin
        gidx = (out_cnt % DIM) * WPR + out_cnt / DIM;
        chk("out_data", out_data, golden[gidx]);
      end
`ifdef CIRC_XPOSE_STATS_EN
      chk("matrix_count", matrix_count, mat_m);
      chk("stall_count", stall_count, stall_m);
      if (out_valid && !out_ready && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
`endif
      if (write_en) begin
        golden[acc_cnt] = in_data;
        acc_cnt++;
      end
      if (read_en) rd_cnt++;
      if (out_valid && out_ready) begin
        out_log.push_back(out_data);
        out_cnt++;
        if (out_cnt == NW) begin
          acc_cnt = 0; rd_cnt = 0; out_cnt = 0; mat_done++;
`ifdef CIRC_XPOSE_STATS_EN
          mat_m = mat_m + 16'd1;
`endif
        end
      end
    end
  end

  task automatic fill(input int first, input bit seq, input logic [WL-1:0] base);
    for (int i = first; i < NW; i++) begin
      in_valid = 1'b1;
      in_data  = seq ? base + WL'(i) : WL'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  logic [WL-1:0] lit_tab [NW] = '{16'h0100, 16'h0102, 16'h0104, 16'h0106,
                                  16'h0101, 16'h0103, 16'h0105, 16'h0107};
  int lat, run, rd_seen, m0, n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Sequential fill then unthrottled drain
    out_ready = 1'b1;
    out_log.delete();
    fill(0, 1'b1, 16'h0100);
    chk("fill_done_in_ready", in_ready, 0);
    chk("fill_done_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("first_word_latency", lat, 2);
    run = 0;
    while (out_valid && run < 20) begin
      run++;
      @(posedge clk); #1;
    end
    chk("consecutive_out_valid", run, NW);
    chk("drain1_count", out_log.size(), NW);
    for (int i = 0; i < NW && i < out_log.size(); i++) chk("drain1_literal", out_log[i], lit_tab[i]);
    chk("drain1_busy", busy, 0);

    // Held-off drain: only two reads may be outstanding
    out_ready = 1'b0;
    fill(0, 1'b0, '0);
    rd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      rd_seen += int'(read_en);
      @(posedge clk); #1;
    end
    chk("stall_reads", rd_seen, 2);
    chk("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_idle(50);

    // Random traffic on both streams
    m0 = mat_done;
    for (int c = 0; c < 600; c++) begin
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = WL'($urandom);
      out_ready = $urandom_range(0, 1) == 1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      in_valid = in_ready;
      in_data  = WL'($urandom);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("random_idle", busy, 0);
    chk("random_matrices", (mat_done - m0) >= 3, 1);

    // Reset in the middle of a drain
    fill(0, 1'b0, '0);
    n = 0;
    while (out_cnt < 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_reset_outputs", out_cnt, 3);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_read_en", read_en, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 16'h0200;
    #1;
    chk("refill_write_en", write_en, 1);
    chk("refill_row", write_row, 0);
    chk("refill_col", write_col, 0);
    @(posedge clk); #1;
    fill(1, 1'b1, 16'h0200);
    out_ready = 1'b1;
    wait_idle(50);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
